clk_gen_monitor: RTL and testbench

- Supervisor on the receiving end of the board clock generator. Runs on BUS_CLK.
- Synchronizes the generator's asynchronous LOCKED output and holds a downstream synchronous reset until lock has been stable.
- Measures the ADC encode clock by oversampling it with BUS_CLK (48 MHz vs 10 MHz) over a fixed gate window.
- Reports frequency, a fault flag and a loss-of-lock event count to the register bank.

---
 rtl/clk_gen_monitor_pkg.sv | 25 ++
 rtl/clk_gen_monitor_sync.sv | 32 +++
 rtl/clk_gen_monitor.sv | 185 ++++++++++++++++++
 tb/tb_clk_gen_monitor.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_gen_monitor_pkg.sv
// Shared types and constants for the clock-generator supervisor.
// Provides the FSM state type, default clock rates, output widths and a
// helper that converts a gate length into the nominal encode edge count.
`timescale 1ns/1ps
package clk_gen_monitor_pkg;

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_SETTLE   = 2'd1,
        ST_RUN      = 2'd2
    } state_e;

    localparam int unsigned BUS_CLK_HZ = 48_000_000;
    localparam int unsigned ENC_HZ     = 10_000_000;
    localparam int unsigned ENC_CNT_W  = 16;
    localparam int unsigned LOSS_CNT_W = 8;

    // Nominal encode rising edges seen in a window of gate_cycles bus clocks.
    function automatic int unsigned expected_enc_count(input int unsigned gate_cycles);
        logic [63:0] prod;
        prod = 64'(gate_cycles) * 64'(ENC_HZ);
        return 32'(prod / 64'(BUS_CLK_HZ));
    endfunction

endpackage

// File: rtl/clk_gen_monitor_sync.sv
// Multi-flop synchronizer for one asynchronous bit.
// Ports: clk, rst_n (synchronous, active low), d (async input),
//        q (d delayed by SYNC_STAGES clk cycles).
`timescale 1ns/1ps
module cdc_sync_bit #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    // Shift the raw input into the chain; bit 0 is the metastable stage.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/clk_gen_monitor.sv
// Clock generator supervisor on BUS_CLK.
// Holds SYS_RST_N low until the generator lock has been stable, measures the
// ADC encode clock over a fixed gate window and tracks lock-loss events.
// Ports:
//   BUS_CLK, BUS_RST_N      - bus clock, synchronous active-low reset
//   LOCKED_IN, ENC_IN       - asynchronous lock flag and encode clock
//   CLEAR_STATS             - pulse, clears LOSS_COUNT
//   SYS_RST_N               - downstream synchronous active-low reset
//   CLK_OK                  - running with an in-range last measurement
//   ENC_COUNT/ENC_VALID     - last window edge count and its update strobe
//   ENC_FAULT               - last window out of [ENC_MIN, ENC_MAX]
//   LOSS_COUNT              - saturating lock-loss event count
`timescale 1ns/1ps
module clk_gen_monitor
    import clk_gen_monitor_pkg::*;
#(
    parameter int unsigned SYNC_STAGES        = 2,
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned GATE_CYCLES        = 48000,
    parameter int unsigned ENC_MIN            = 9990,
    parameter int unsigned ENC_MAX            = 10010
) (
    input  logic                  BUS_CLK,
    input  logic                  BUS_RST_N,
    input  logic                  LOCKED_IN,
    input  logic                  ENC_IN,
    input  logic                  CLEAR_STATS,
    output logic                  SYS_RST_N,
    output logic                  CLK_OK,
    output logic [ENC_CNT_W-1:0]  ENC_COUNT,
    output logic                  ENC_VALID,
    output logic                  ENC_FAULT,
    output logic [LOSS_CNT_W-1:0] LOSS_COUNT
);

    localparam int unsigned SETTLE_W = (LOCK_STABLE_CYCLES > 1) ? $clog2(LOCK_STABLE_CYCLES) : 1;
    localparam int unsigned GATE_W   = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [SETTLE_W-1:0]   SETTLE_LAST  = SETTLE_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [GATE_W-1:0]     GATE_LAST    = GATE_W'(GATE_CYCLES - 1);
    localparam logic [ENC_CNT_W-1:0]  ENC_CNT_MAX  = '1;
    localparam logic [LOSS_CNT_W-1:0] LOSS_CNT_MAX = '1;

    logic lock_s;
    logic enc_s;

    state_e                  state_q, state_d;
    logic [SETTLE_W-1:0]     settle_q, settle_d;
    logic [GATE_W-1:0]       gate_q, gate_d;
    logic [ENC_CNT_W-1:0]    edge_q, edge_d;
    logic                    enc_prev_q, enc_prev_d;
    logic                    win_done_q, win_done_d;
    logic                    sys_rst_n_q, sys_rst_n_d;
    logic                    clk_ok_q, clk_ok_d;
    logic [ENC_CNT_W-1:0]    enc_count_q, enc_count_d;
    logic                    enc_valid_q, enc_valid_d;
    logic                    enc_fault_q, enc_fault_d;
    logic [LOSS_CNT_W-1:0]   loss_q, loss_d;

    logic                    enc_rise;
    logic [ENC_CNT_W-1:0]    win_total;
    logic                    win_end;
    logic                    loss_evt;

    cdc_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lock (
        .clk   (BUS_CLK),
        .rst_n (BUS_RST_N),
        .d     (LOCKED_IN),
        .q     (lock_s)
    );

    cdc_sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync_enc (
        .clk   (BUS_CLK),
        .rst_n (BUS_RST_N),
        .d     (ENC_IN),
        .q     (enc_s)
    );

    // Lock FSM, gate/edge counters, measurement result and loss statistics.
    always_comb begin
        state_d     = state_q;
        settle_d    = settle_q;
        gate_d      = '0;
        edge_d      = '0;
        win_done_d  = 1'b0;
        enc_prev_d  = enc_s;
        enc_count_d = enc_count_q;
        enc_valid_d = 1'b0;
        enc_fault_d = enc_fault_q;
        loss_d      = loss_q;
        win_end     = 1'b0;
        loss_evt    = 1'b0;

        enc_rise  = enc_s & ~enc_prev_q;
        // Running total including an edge on the current cycle, saturating.
        win_total = (edge_q == ENC_CNT_MAX) ? edge_q : edge_q + ENC_CNT_W'(enc_rise);

        case (state_q)
            ST_UNLOCKED: begin
                if (lock_s) begin
                    state_d  = ST_SETTLE;
                    settle_d = '0;
                end
            end
            ST_SETTLE: begin
                if (!lock_s) begin
                    state_d = ST_UNLOCKED;
                end else if (settle_q == SETTLE_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    settle_d = settle_q + SETTLE_W'(1);
                end
            end
            ST_RUN: begin
                if (!lock_s) begin
                    state_d  = ST_UNLOCKED;
                    loss_evt = 1'b1;
                end
            end
            default: state_d = ST_UNLOCKED;
        endcase

        // Counters advance only while staying in RUN; a lock loss discards the window.
        if ((state_q == ST_RUN) && (state_d == ST_RUN)) begin
            win_end    = (gate_q == GATE_LAST);
            gate_d     = win_end ? '0 : gate_q + GATE_W'(1);
            edge_d     = win_end ? '0 : win_total;
            win_done_d = win_done_q | win_end;
        end

        if (win_end) begin
            enc_count_d = win_total;
            enc_valid_d = 1'b1;
            enc_fault_d = (32'(win_total) < ENC_MIN) || (32'(win_total) > ENC_MAX);
        end

        // A clear coinciding with a loss event still records that event.
        if (CLEAR_STATS) begin
            loss_d = '0;
        end
        if (loss_evt && (loss_d != LOSS_CNT_MAX)) begin
            loss_d = loss_d + LOSS_CNT_W'(1);
        end

        sys_rst_n_d = (state_d == ST_RUN);
        clk_ok_d    = (state_d == ST_RUN) && win_done_d && !enc_fault_d;
    end

    always_ff @(posedge BUS_CLK) begin
        if (!BUS_RST_N) begin
            state_q     <= ST_UNLOCKED;
            settle_q    <= '0;
            gate_q      <= '0;
            edge_q      <= '0;
            enc_prev_q  <= 1'b0;
            win_done_q  <= 1'b0;
            sys_rst_n_q <= 1'b0;
            clk_ok_q    <= 1'b0;
            enc_count_q <= '0;
            enc_valid_q <= 1'b0;
            enc_fault_q <= 1'b0;
            loss_q      <= '0;
        end else begin
            state_q     <= state_d;
            settle_q    <= settle_d;
            gate_q      <= gate_d;
            edge_q      <= edge_d;
            enc_prev_q  <= enc_prev_d;
            win_done_q  <= win_done_d;
            sys_rst_n_q <= sys_rst_n_d;
            clk_ok_q    <= clk_ok_d;
            enc_count_q <= enc_count_d;
            enc_valid_q <= enc_valid_d;
            enc_fault_q <= enc_fault_d;
            loss_q      <= loss_d;
        end
    end

    assign SYS_RST_N  = sys_rst_n_q;
    assign CLK_OK     = clk_ok_q;
    assign ENC_COUNT  = enc_count_q;
    assign ENC_VALID  = enc_valid_q;
    assign ENC_FAULT  = enc_fault_q;
    assign LOSS_COUNT = loss_q;

endmodule

// File: tb/tb_clk_gen_monitor.sv
// Self-checking bench for clk_gen_monitor with shortened sim parameters.
// A run-length / sliding-window model predicts every output each cycle;
// directed scenarios add literal expectations on latencies and counts.
`timescale 1ns/1ps
module tb_clk_gen_monitor;

    localparam int S    = 2;
    localparam int L    = 16;
    localparam int G    = 480;
    localparam int EMIN = 99;
    localparam int EMAX = 101;

    logic        BUS_CLK = 1'b0;
    logic        BUS_RST_N;
    logic        LOCKED_IN;
    logic        ENC_IN;
    logic        CLEAR_STATS;
    logic        SYS_RST_N;
    logic        CLK_OK;
    logic [15:0] ENC_COUNT;
    logic        ENC_VALID;
    logic        ENC_FAULT;
    logic [7:0]  LOSS_COUNT;

    int n_cmp = 0;
    int n_err = 0;

    int enc_step = 20;   // phase advance per bus cycle, 96 = one encode period
    bit enc_hold = 1'b0;
    int phase    = 0;

    clk_gen_monitor #(
        .SYNC_STAGES        (S),
        .LOCK_STABLE_CYCLES (L),
        .GATE_CYCLES        (G),
        .ENC_MIN            (EMIN),
        .ENC_MAX            (EMAX)
    ) dut (
        .BUS_CLK     (BUS_CLK),
        .BUS_RST_N   (BUS_RST_N),
        .LOCKED_IN   (LOCKED_IN),
        .ENC_IN      (ENC_IN),
        .CLEAR_STATS (CLEAR_STATS),
        .SYS_RST_N   (SYS_RST_N),
        .CLK_OK      (CLK_OK),
        .ENC_COUNT   (ENC_COUNT),
        .ENC_VALID   (ENC_VALID),
        .ENC_FAULT   (ENC_FAULT),
        .LOSS_COUNT  (LOSS_COUNT)
    );

    always #10 BUS_CLK = ~BUS_CLK;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Encode clock: 48/96*enc_step MHz square wave sampled on the bus grid.
    initial begin
        ENC_IN = 1'b0;
        forever begin
            @(posedge BUS_CLK);
            #1;
            phase  = (phase + enc_step) % 96;
            ENC_IN = enc_hold ? 1'b0 : (phase >= 48);
        end
    end

    // Model: RUN holds once synchronized lock has been high for L+1 edges;
    // a window completes every G edges of continuous RUN after entry.
    logic lkq[$];
    logic enq[$];
    int   winq[$];
    bit   model_ok = 1'b0;
    bit   m_run, was_run, m_sys, m_ok, m_valid, m_fault;
    logic ls, es, es_prev, rise;
    int   runlen, pos, m_cnt, m_loss, sum;

    initial begin
        forever begin
            @(posedge BUS_CLK);
            if (!BUS_RST_N) begin
                lkq.delete();
                enq.delete();
                for (int i = 0; i < S; i++) begin
                    lkq.push_back(1'b0);
                    enq.push_back(1'b0);
                end
                winq.delete();
                es_prev = 1'b0;
                runlen  = 0;
                m_run   = 1'b0;
                m_sys   = 1'b0;
                m_ok    = 1'b0;
                m_cnt   = 0;
                m_valid = 1'b0;
                m_fault = 1'b0;
                m_loss  = 0;
                model_ok = 1'b1;
            end else if (model_ok) begin
                ls = lkq.pop_front();
                lkq.push_back(LOCKED_IN);
                es = enq.pop_front();
                enq.push_back(ENC_IN);
                rise    = es & ~es_prev;
                es_prev = es;
                was_run = m_run;
                if (was_run && !ls) begin
                    m_loss = CLEAR_STATS ? 1 : ((m_loss >= 255) ? 255 : m_loss + 1);
                end else if (CLEAR_STATS) begin
                    m_loss = 0;
                end
                runlen = ls ? runlen + 1 : 0;
                m_run  = (runlen >= L + 1);
                pos    = runlen - (L + 1);
                if (m_run && was_run) begin
                    winq.push_back(int'(rise));
                    if (winq.size() > G) void'(winq.pop_front());
                end else if (!m_run) begin
                    winq.delete();
                end
                m_valid = 1'b0;
                if (m_run && pos >= G && (pos % G) == 0) begin
                    sum = 0;
                    foreach (winq[i]) sum += winq[i];
                    m_cnt   = (sum > 65535) ? 65535 : sum;
                    m_fault = (m_cnt < EMIN) || (m_cnt > EMAX);
                    m_valid = 1'b1;
                end
                m_sys = m_run;
                m_ok  = m_run && (pos >= G) && !m_fault;
            end
        end
    end

    // Cycle-by-cycle comparison against the model on the falling edge.
    initial begin
        forever begin
            @(negedge BUS_CLK);
            if (model_ok) begin
                chk("m_sys_rst_n", 16'(SYS_RST_N), 16'(m_sys));
                chk("m_clk_ok",    16'(CLK_OK),    16'(m_ok));
                chk("m_enc_count", ENC_COUNT,      16'(m_cnt));
                chk("m_enc_valid", 16'(ENC_VALID), 16'(m_valid));
                chk("m_enc_fault", 16'(ENC_FAULT), 16'(m_fault));
                chk("m_loss",      16'(LOSS_COUNT), 16'(m_loss));
            end
        end
    end

    task automatic tick();
        @(posedge BUS_CLK);
        #1;
    endtask

    task automatic wait_sys(input logic lvl, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (SYS_RST_N !== lvl && n < 200);
        if (SYS_RST_N !== lvl) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_sys: SYS_RST_N=%b never reached %b", SYS_RST_N, lvl);
        end
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (ENC_VALID !== 1'b1 && n < 1200);
        if (ENC_VALID !== 1'b1) begin
            n_cmp++;
            n_err++;
            $display("FAIL wait_valid: ENC_VALID=%b after %0d cycles, required 1", ENC_VALID, n);
        end
    endtask

    initial begin
        #1_900_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int n;

    initial begin
        BUS_RST_N   = 1'b0;
        LOCKED_IN   = 1'b0;
        CLEAR_STATS = 1'b0;
        repeat (3) tick();
        chk("rst_sys_rst_n", 16'(SYS_RST_N), 16'd0);
        chk("rst_clk_ok",    16'(CLK_OK),    16'd0);
        chk("rst_enc_count", ENC_COUNT,      16'd0);
        chk("rst_enc_valid", 16'(ENC_VALID), 16'd0);
        chk("rst_enc_fault", 16'(ENC_FAULT), 16'd0);
        chk("rst_loss",      16'(LOSS_COUNT), 16'd0);
        BUS_RST_N = 1'b1;

        // Lock release: S sync + 1 detect + L settle cycles.
        repeat (10) tick();
        LOCKED_IN = 1'b1;
        wait_sys(1'b1, n);
        chk("lock_latency", 16'(n), 16'd19);
        chk("lock_clk_ok_low", 16'(CLK_OK), 16'd0);

        // Nominal 10 MHz.
        wait_valid(n);
        chk("first_window_len", 16'(n), 16'd480);
        chk("nom_count", ENC_COUNT, 16'd100);
        chk("nom_fault", 16'(ENC_FAULT), 16'd0);
        chk("nom_clk_ok", 16'(CLK_OK), 16'd1);
        wait_valid(n);
        chk("nom_period", 16'(n), 16'd480);
        chk("nom_count2", ENC_COUNT, 16'd100);

        // 9 MHz: first window is mixed, second is clean.
        enc_step = 18;
        wait_valid(n);
        wait_valid(n);
        chk("slow_count", ENC_COUNT, 16'd90);
        chk("slow_fault", 16'(ENC_FAULT), 16'd1);
        chk("slow_clk_ok", 16'(CLK_OK), 16'd0);

        // Encode clock stuck low.
        enc_hold = 1'b1;
        wait_valid(n);
        wait_valid(n);
        chk("stuck_count", ENC_COUNT, 16'd0);
        chk("stuck_fault", 16'(ENC_FAULT), 16'd1);
        chk("stuck_sys_rst_n", 16'(SYS_RST_N), 16'd1);

        enc_hold = 1'b0;
        enc_step = 20;
        wait_valid(n);
        wait_valid(n);
        chk("recover_count", ENC_COUNT, 16'd100);
        chk("recover_clk_ok", 16'(CLK_OK), 16'd1);

        // Lock loss 200 cycles into a window.
        repeat (200) tick();
        LOCKED_IN = 1'b0;
        wait_sys(1'b0, n);
        chk("loss_latency", 16'(n), 16'd3);
        chk("loss_clk_ok", 16'(CLK_OK), 16'd0);
        chk("loss_count1", 16'(LOSS_COUNT), 16'd1);
        chk("loss_enc_count_kept", ENC_COUNT, 16'd100);
        LOCKED_IN = 1'b1;
        wait_sys(1'b1, n);
        chk("relock_latency", 16'(n), 16'd19);
        wait_valid(n);
        chk("relock_window_len", 16'(n), 16'd480);
        chk("relock_count", ENC_COUNT, 16'd100);

        // Clear, then a one-cycle glitch during SETTLE.
        LOCKED_IN = 1'b0;
        repeat (10) tick();
        CLEAR_STATS = 1'b1;
        tick();
        CLEAR_STATS = 1'b0;
        chk("clear_loss", 16'(LOSS_COUNT), 16'd0);
        LOCKED_IN = 1'b1;
        repeat (5) tick();
        LOCKED_IN = 1'b0;
        tick();
        LOCKED_IN = 1'b1;
        wait_sys(1'b1, n);
        chk("glitch_latency", 16'(n), 16'd19);
        chk("glitch_loss", 16'(LOSS_COUNT), 16'd0);

        // 256 loss events saturate at 255.
        for (int i = 0; i < 256; i++) begin
            if (i > 0) begin
                LOCKED_IN = 1'b1;
                wait_sys(1'b1, n);
            end
            LOCKED_IN = 1'b0;
            wait_sys(1'b0, n);
        end
        chk("loss_saturate", 16'(LOSS_COUNT), 16'd255);

        // CLEAR_STATS on the same edge as a loss event.
        LOCKED_IN = 1'b1;
        wait_sys(1'b1, n);
        LOCKED_IN = 1'b0;
        tick();
        tick();
        CLEAR_STATS = 1'b1;
        tick();
        CLEAR_STATS = 1'b0;
        chk("clr_loss_sys_rst_n", 16'(SYS_RST_N), 16'd0);
        chk("clr_loss_count", 16'(LOSS_COUNT), 16'd1);

        // Reset in the middle of a window.
        LOCKED_IN = 1'b1;
        wait_sys(1'b1, n);
        wait_valid(n);
        repeat (100) tick();
        BUS_RST_N = 1'b0;
        tick();
        chk("mid_rst_sys_rst_n", 16'(SYS_RST_N), 16'd0);
        chk("mid_rst_clk_ok",    16'(CLK_OK),    16'd0);
        chk("mid_rst_enc_count", ENC_COUNT,      16'd0);
        chk("mid_rst_enc_valid", 16'(ENC_VALID), 16'd0);
        chk("mid_rst_enc_fault", 16'(ENC_FAULT), 16'd0);
        chk("mid_rst_loss",      16'(LOSS_COUNT), 16'd0);
        BUS_RST_N = 1'b1;
        wait_sys(1'b1, n);
        chk("post_rst_latency", 16'(n), 16'd19);
        wait_valid(n);
        chk("post_rst_count", ENC_COUNT, 16'd100);
        repeat (5) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
